regfile_access_ctrl: RTL

Initiator-side controller for the single-index register file: sequences writeback requests and two-operand (rs1/rs2) read requests over the file's one shared index port. Decode/issue sits upstream on the read side and writeback on the write side. The controller owns all rf_* signals, arbitrates write over read, hardwires x0, and returns both operands in one response beat.

---
 rtl/regfile_access_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/regfile_access_ctrl.sv
// Initiator-side sequencer for a single-index register file: serialises writebacks
// and two-operand reads over one shared index port, with x0 hardwired to zero.
module regfile_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [ADDR_WIDTH-1:0] rd_rs1,
    input  logic [ADDR_WIDTH-1:0] rd_rs2,
    output logic                  rd_rsp_valid,
    input  logic                  rd_rsp_ready,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [ADDR_WIDTH-1:0] wb_index,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [ADDR_WIDTH-1:0] rf_index,
    output logic [DATA_WIDTH-1:0] rf_valueInput,
    output logic                  rf_readEnable,
    output logic                  rf_writeEnable,
    input  logic [DATA_WIDTH-1:0] rf_valueOutput
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_RD1,
        S_RD2,
        S_CAP,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] wb_index_q, wb_index_d;
    logic [DATA_WIDTH-1:0] wb_data_q,  wb_data_d;
    logic [ADDR_WIDTH-1:0] rs1_q,      rs1_d;
    logic [ADDR_WIDTH-1:0] rs2_q,      rs2_d;
    logic [DATA_WIDTH-1:0] data1_q,    data1_d;
    logic [DATA_WIDTH-1:0] data2_q,    data2_d;

    logic idle;

    // Ready outputs are masked by reset so nothing looks acceptable while it is held.
    assign idle         = (state_q == S_IDLE) && reset;
    assign wb_ready     = idle;
    assign rd_req_ready = idle && !wb_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (wb_valid) begin
                    state_d = S_WB;
                end else if (rd_req_valid) begin
                    state_d = S_RD1;
                end
            end
            S_WB:    state_d = S_IDLE;
            S_RD1:   state_d = S_RD2;
            S_RD2:   state_d = S_CAP;
            S_CAP:   state_d = S_RESP;
            S_RESP: begin
                if (rd_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rf_index       = '0;
        rf_valueInput  = '0;
        rf_readEnable  = 1'b0;
        rf_writeEnable = 1'b0;
        rd_rsp_valid   = 1'b0;
        case (state_q)
            S_WB: begin
                rf_index       = wb_index_q;
                rf_valueInput  = wb_data_q;
                rf_writeEnable = (wb_index_q != '0);
            end
            S_RD1: begin
                rf_index      = rs1_q;
                rf_readEnable = (rs1_q != '0);
            end
            S_RD2: begin
                rf_index      = rs2_q;
                rf_readEnable = (rs2_q != '0);
            end
            S_RESP:  rd_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign rd_data1 = data1_q;
    assign rd_data2 = data2_q;

    // File read data lags its strobe by one cycle: rs1 lands during RD2, rs2 during CAP.
    always_comb begin
        wb_index_d = wb_index_q;
        wb_data_d  = wb_data_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        data1_d    = data1_q;
        data2_d    = data2_q;
        case (state_q)
            S_IDLE: begin
                if (wb_valid) begin
                    wb_index_d = wb_index;
                    wb_data_d  = wb_data;
                end else if (rd_req_valid) begin
                    rs1_d = rd_rs1;
                    rs2_d = rd_rs2;
                end
            end
            S_RD2:   data1_d = (rs1_q != '0) ? rf_valueOutput : '0;
            S_CAP:   data2_d = (rs2_q != '0) ? rf_valueOutput : '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_index_q <= '0;
            wb_data_q  <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            data1_q    <= '0;
            data2_q    <= '0;
        end else begin
            wb_index_q <= wb_index_d;
            wb_data_q  <= wb_data_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            data1_q    <= data1_d;
            data2_q    <= data2_d;
        end
    end

endmodule
